// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the pixel/colour block.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer samples the raster whenever p_tick is high.
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_end;

  // Generator side drives the raster.
  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_end
  );

  // Pixel block and game logic only observe it.
  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_end
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-enable divider, x/y counters, sync/blank/frame-end flags.
// Latency: flags are registered from next (x, y), so they align with x/y; p_tick one clk after divider terminal count.
// Backpressure: none; the raster free-runs and never stalls.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A 1-bit divider is kept even for CLK_DIV == 1; it simply sits at 0 and wraps every clk.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             p_tick_q, p_tick_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_end_q, frame_end_d;

  // Next-state: divider wrap advances the raster; flags decode the coordinate about to be loaded.
  always_comb begin
    wrap  = (div_q == DIV_LAST);
    div_d = wrap ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (wrap) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    p_tick_d    = wrap;
    video_on_d  = (x_d < X_VIS) && (y_d < Y_VIS);
    hsync_d     = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    // Only the advancing edge into (0, V_DISPLAY) counts, so the pulse lasts one clk.
    frame_end_d = wrap && (x_d == '0) && (y_d == Y_VIS);
  end

  // Pixel-enable divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
    end
  end

  // Raster position and its decoded flags, loaded together so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      video_on_q  <= 1'b1;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      frame_end_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      video_on_q  <= video_on_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign vga.p_tick    = p_tick_q;
  assign vga.x         = x_q;
  assign vga.y         = y_q;
  assign vga.video_on  = video_on_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.frame_end = frame_end_q;

endmodule
